// File: rtl/baud_pkg.sv
// Shared constants and the elaboration-time increment calculation for the
// fractional baud generator.
package baud_pkg;

   localparam int SEL_W = 3;

   // Baud rate for each value of the rate select; 6 and 7 alias 9600.
   localparam int unsigned BAUD_TABLE [0:7] = '{
      32'd1200, 32'd9600, 32'd19200, 32'd38400,
      32'd57600, 32'd115200, 32'd9600, 32'd9600
   };

   // Phase increment round(baud*ovs*2^acc_w / clk_hz). A package cannot
   // depend on ACC_W, so the result is returned at 64 bits; the caller
   // range-checks it against 2^ACC_W and narrows it.
   function automatic logic [63:0] baud_inc(input longint unsigned clk_hz,
                                            input longint unsigned baud,
                                            input longint unsigned ovs,
                                            input int unsigned acc_w);
      longint unsigned num;
      num = (baud * ovs) << acc_w;
      return (2 * num + clk_hz) / (2 * clk_hz);
   endfunction

endpackage

// File: rtl/frac_tick.sv
// Fractional phase accumulator: adds inc every cycle and reports the carry
// out of the top bit, which marks one oversample period.
module frac_tick #(
   parameter int ACC_W = 24
) (
   input  logic             clki,
   input  logic             rstn,
   input  logic             clr,
   input  logic [ACC_W-1:0] inc,
   output logic             carry
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;

   // One extra bit on the sum holds the wrap-around carry.
   always_comb begin
      sum = {1'b0, acc} + {1'b0, inc};
   end

   // A cleared cycle never reports a carry, so no strobe leaks out of a
   // restart.
   assign carry = sum[ACC_W] & ~clr;

   // Accumulate phase; restart from zero on reset or clear.
   always_ff @(posedge clki) begin
      if (!rstn || clr) begin
         acc <= '0;
      end else begin
         acc <= sum[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/baud_gen.sv
// Run-time selectable UART baud generator. A fractional accumulator gives
// the oversample rate; a small counter derives mid-bit and bit-boundary
// strobes and a square wave at the baud rate.
module baud_gen
   import baud_pkg::*;
#(
   parameter int CLK_HZ = 24000000,
   parameter int OVS    = 16,
   parameter int ACC_W  = 24
) (
   input  logic             clki,
   input  logic             rstn,
   input  logic             en,
   input  logic [SEL_W-1:0] sel,
   output logic             tick_ovs,
   output logic             tick_mid,
   output logic             tick_baud,
   output logic             clko
);

   localparam int             CNT_W   = $clog2(OVS);
   localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(OVS / 2 - 1);
   localparam logic [CNT_W-1:0] END_CNT = CNT_W'(OVS - 1);
   localparam logic [63:0]    INC_LIM = 64'd1 << ACC_W;

   function automatic logic [63:0] raw_inc(input int idx);
      return baud_inc(64'(CLK_HZ), 64'(BAUD_TABLE[idx]), 64'(OVS), ACC_W);
   endfunction

   function automatic logic [ACC_W-1:0] inc_of(input int idx);
      return ACC_W'(raw_inc(idx));
   endfunction

   localparam logic [ACC_W-1:0] INC_TAB [0:7] = '{
      inc_of(0), inc_of(1), inc_of(2), inc_of(3),
      inc_of(4), inc_of(5), inc_of(6), inc_of(7)
   };

   // An increment of zero never ticks, and one at or above 2^ACC_W would
   // need more than one carry per cycle; refuse both at elaboration.
   for (genvar g = 0; g < 8; g++) begin : g_inc_chk
      if (raw_inc(g) == 64'd0 || raw_inc(g) >= INC_LIM) begin : g_bad
         $error("baud_gen: rate index %0d gives an increment outside 1..2^ACC_W-1", g);
      end
   end

   if (OVS < 4 || OVS > 64 || (OVS % 2) != 0) begin : g_ovs_bad
      $error("baud_gen: OVS must be even and within 4..64");
   end

   logic [SEL_W-1:0] sel_q;
   logic [ACC_W-1:0] inc;
   logic [CNT_W-1:0] ovs_cnt;
   logic             clr;
   logic             carry;
   logic             at_mid;
   logic             at_end;

   // A rate change restarts the generator just like a disable does, so the
   // new rate always starts from phase zero.
   assign clr    = !en || (sel != sel_q);
   assign at_mid = (ovs_cnt == MID_CNT);
   assign at_end = (ovs_cnt == END_CNT);

   // Latch the selected rate and its increment whenever the select moves.
   always_ff @(posedge clki) begin
      if (!rstn || (sel != sel_q)) begin
         sel_q <= sel;
         inc   <= INC_TAB[sel];
      end
   end

   frac_tick #(
      .ACC_W (ACC_W)
   ) u_frac (
      .clki  (clki),
      .rstn  (rstn),
      .clr   (clr),
      .inc   (inc),
      .carry (carry)
   );

   // Count oversample carries within a bit, register the strobes and flip
   // clko at mid-bit and at the bit boundary.
   always_ff @(posedge clki) begin
      if (!rstn || clr) begin
         ovs_cnt   <= '0;
         tick_ovs  <= 1'b0;
         tick_mid  <= 1'b0;
         tick_baud <= 1'b0;
         clko      <= 1'b0;
      end else begin
         tick_ovs  <= carry;
         tick_mid  <= carry && at_mid;
         tick_baud <= carry && at_end;
         if (carry) begin
            ovs_cnt <= at_end ? '0 : ovs_cnt + 1'b1;
            if (at_mid || at_end) begin
               clko <= ~clko;
            end
         end
      end
   end

endmodule

// File: tb/tb_baud_gen.sv
// Bench for baud_gen: a 24 MHz / OVS=16 instance and a 12 MHz / OVS=8
// instance share the stimulus; a tick-count model predicts every output.
module tb_baud_gen;

   localparam int ACC_W = 24;
   localparam longint unsigned ONE = 64'd1 << ACC_W;
   localparam int CLKS [0:1] = '{24000000, 12000000};
   localparam int OVSS [0:1] = '{16, 8};
   localparam int RATE [0:7] = '{1200, 9600, 19200, 38400, 57600, 115200, 9600, 9600};
   localparam int SWEEP_M [0:7] = '{1, 2, 2, 4, 4, 8, 1, 1};

   logic       clki = 1'b0;
   logic       rstn = 1'b0;
   logic       en   = 1'b0;
   logic [2:0] sel  = 3'd5;
   logic [1:0] ovs_o, mid_o, baud_o, clko_o;

   longint          cyc = 0;
   longint          t0  = 0;
   int              n_chk = 0;
   int              n_fail = 0;
   int              timeouts = 0;
   logic [2:0]      m_sel [0:1];
   longint unsigned m_n [0:1] = '{64'd0, 64'd0};
   logic [3:0]      exp_vec [0:1] = '{4'd0, 4'd0};
   longint          prev_ovs [0:1] = '{-64'sd1, -64'sd1};
   longint          prev_baud [0:1] = '{-64'sd1, -64'sd1};

   baud_gen #(.CLK_HZ(24000000), .OVS(16), .ACC_W(ACC_W)) dut (
      .clki(clki), .rstn(rstn), .en(en), .sel(sel),
      .tick_ovs(ovs_o[0]), .tick_mid(mid_o[0]), .tick_baud(baud_o[0]), .clko(clko_o[0])
   );

   baud_gen #(.CLK_HZ(12000000), .OVS(8), .ACC_W(ACC_W)) dut8 (
      .clki(clki), .rstn(rstn), .en(en), .sel(sel),
      .tick_ovs(ovs_o[1]), .tick_mid(mid_o[1]), .tick_baud(baud_o[1]), .clko(clko_o[1])
   );

   always #5 clki = ~clki;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic longint unsigned ceil_div(input longint unsigned a, input longint unsigned b);
      return (a + b - 1) / b;
   endfunction

   function automatic longint unsigned inc_for(input int d, input int s);
      longint unsigned num, clk;
      clk = longint'(CLKS[d]);
      num = (longint'(RATE[s]) * longint'(OVSS[d])) << ACC_W;
      return (2 * num + clk) / (2 * clk);
   endfunction

   // After n enabled edges the accumulator has wrapped floor(n*inc/2^A)
   // times; everything follows from that tick count k.
   function automatic logic [3:0] model_out(input int d, input logic [2:0] s, input longint unsigned n);
      longint unsigned inc, k, kp, ov;
      logic t;
      inc = inc_for(d, int'(s));
      k   = (n * inc) >> ACC_W;
      kp  = ((n - 1) * inc) >> ACC_W;
      t   = (k != kp);
      ov  = longint'(OVSS[d]);
      return {t, t && (k % ov == ov / 2), t && (k % ov == 0), ((k / (ov / 2)) % 2) == 1};
   endfunction

   always @(posedge clki) begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) begin
         if (!rstn || sel != m_sel[d]) begin
            m_sel[d]   <= sel;
            m_n[d]     <= 0;
            exp_vec[d] <= 4'd0;
         end else if (!en) begin
            m_n[d]     <= 0;
            exp_vec[d] <= 4'd0;
         end else begin
            m_n[d]     <= m_n[d] + 1;
            exp_vec[d] <= model_out(d, m_sel[d], m_n[d] + 1);
         end
      end
   end

   task automatic monitor();
      longint unsigned inc;
      longint gap, lo, hi;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d_outputs", d), {ovs_o[d], mid_o[d], baud_o[d], clko_o[d]}, exp_vec[d]);
         if (m_n[d] == 0) begin
            prev_ovs[d]  = -1;
            prev_baud[d] = -1;
         end else begin
            inc = inc_for(d, int'(m_sel[d]));
            if (ovs_o[d]) begin
               if (prev_ovs[d] >= 0) begin
                  gap = cyc - prev_ovs[d];
                  lo  = longint'(ONE / inc);
                  hi  = longint'(ceil_div(ONE, inc));
                  check($sformatf("d%0d_ovs_gap", d), gap, clamp(gap, lo, hi));
               end
               prev_ovs[d] = cyc;
            end
            if (baud_o[d]) begin
               if (prev_baud[d] >= 0) begin
                  gap = cyc - prev_baud[d];
                  lo  = longint'((longint'(OVSS[d]) * ONE) / inc);
                  hi  = longint'(ceil_div(longint'(OVSS[d]) * ONE, inc));
                  check($sformatf("d%0d_baud_gap", d), gap, clamp(gap, lo, hi));
               end
               prev_baud[d] = cyc;
            end
         end
      end
   endtask

   always @(negedge clki) begin
      if (cyc > 0) monitor();
   end

   function automatic logic pick(input int d, input int which);
      case (which)
         0:       return ovs_o[d];
         1:       return mid_o[d];
         default: return baud_o[d];
      endcase
   endfunction

   // Edge number (relative to t0) of the next strobe, or -1 on timeout.
   task automatic wait_for(input int d, input int which, output longint edge_no);
      int limit;
      limit   = (timeouts > 0) ? 500 : 25000;
      edge_no = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clki);
         if (pick(d, which)) begin
            edge_no = cyc - t0;
            break;
         end
      end
      if (edge_no < 0) timeouts++;
   endtask

   task automatic first_bit(input int d, input longint e_ovs, input longint e_mid, input longint e_baud);
      longint e;
      wait_for(d, 0, e);
      check($sformatf("d%0d_first_ovs_edge", d), e, e_ovs);
      wait_for(d, 1, e);
      check($sformatf("d%0d_first_mid_edge", d), e, e_mid);
      check($sformatf("d%0d_mid_with_ovs", d), ovs_o[d], 1);
      check($sformatf("d%0d_clko_rise", d), clko_o[d], 1);
      wait_for(d, 2, e);
      check($sformatf("d%0d_first_baud_edge", d), e, e_baud);
      check($sformatf("d%0d_clko_fall", d), clko_o[d], 0);
   endtask

   initial begin
      longint e, e_prev, e_first, err, tol;
      longint unsigned inc2;

      // Reset state
      repeat (3) @(negedge clki);
      check("reset_outputs_d0", {ovs_o[0], mid_o[0], baud_o[0], clko_o[0]}, 0);
      check("reset_outputs_d1", {ovs_o[1], mid_o[1], baud_o[1], clko_o[1]}, 0);
      check("reset_inc_sel5", dut.inc, 1288490);

      // First bit at 115200 from the first post-reset edge
      rstn = 1'b1; en = 1'b1; t0 = cyc;
      first_bit(0, 14, 105, 209);

      // Disable mid-bit for 3 cycles, then the same timing from re-enable
      repeat (50) @(negedge clki);
      en = 1'b0;
      repeat (3) @(negedge clki);
      check("en_low_clear_d0", {ovs_o[0], mid_o[0], baud_o[0], clko_o[0]}, 0);
      check("en_low_clear_d1", {ovs_o[1], mid_o[1], baud_o[1], clko_o[1]}, 0);
      en = 1'b1; t0 = cyc;
      first_bit(0, 14, 105, 209);

      // Switch 115200 -> 19200 with ovs_cnt at 7
      for (int i = 0; i < 7; i++) wait_for(0, 0, e);
      repeat (3) @(negedge clki);
      sel = 3'd2;
      @(negedge clki);
      check("switch_edge_clear", {ovs_o[0], mid_o[0], baud_o[0], clko_o[0]}, 0);
      t0 = cyc;
      inc2 = inc_for(0, 2);
      first_bit(0, longint'(ceil_div(ONE, inc2)), longint'(ceil_div(8 * ONE, inc2)),
                longint'(ceil_div(16 * ONE, inc2)));

      // 9600 for 6 bit periods
      sel = 3'd1;
      @(negedge clki);
      t0 = cyc;
      check("inc_sel1", dut.inc, 107374);
      wait_for(0, 2, e_first);
      e_prev = e_first;
      for (int i = 0; i < 6; i++) begin
         wait_for(0, 2, e);
         check("s9600_baud_gap", e - e_prev, 2500);
         e_prev = e;
      end
      check("s9600_span6", e_prev - e_first, clamp(e_prev - e_first, 14999, 15001));

      // Rate sweep: time to the M-th bit boundary within 0.01% (+1 cycle)
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s);
         @(negedge clki);
         t0 = cyc;
         e = -1;
         for (int j = 0; j < SWEEP_M[s]; j++) wait_for(0, 2, e);
         err = e * RATE[s] - longint'(SWEEP_M[s]) * CLKS[0];
         if (err < 0) err = -err;
         tol = RATE[s] + (longint'(SWEEP_M[s]) * CLKS[0]) / 10000;
         check($sformatf("sweep_sel%0d_rate_err", s), err, clamp(err, 0, tol));
      end

      // Randomised select changes, disables and resets
      for (int it = 0; it < 30; it++) begin
         int unsigned act;
         act = $urandom_range(0, 3);
         case (act)
            0: sel = 3'($urandom_range(0, 7));
            1: begin
               en = 1'b0;
               repeat ($urandom_range(1, 4)) @(negedge clki);
               en = 1'b1;
            end
            2: begin
               rstn = 1'b0;
               sel  = 3'($urandom_range(0, 7));
               repeat ($urandom_range(1, 2)) @(negedge clki);
               rstn = 1'b1;
            end
            default: ;
         endcase
         repeat ($urandom_range(20, 300)) @(negedge clki);
      end

      // One-cycle reset on the edge where both instances would strobe tick_baud
      rstn = 1'b0; sel = 3'd5; en = 1'b1;
      @(negedge clki);
      rstn = 1'b1; t0 = cyc;
      repeat (208) @(negedge clki);
      rstn = 1'b0;
      @(negedge clki);
      check("reset_no_glitch_d0", {ovs_o[0], mid_o[0], baud_o[0], clko_o[0]}, 0);
      check("reset_no_glitch_d1", {ovs_o[1], mid_o[1], baud_o[1], clko_o[1]}, 0);
      rstn = 1'b1; t0 = cyc;
      first_bit(1, 14, 53, 105);
      e_prev = cyc - t0;
      wait_for(1, 2, e);
      check("d1_baud_gap", e - e_prev, clamp(e - e_prev, 104, 105));

      repeat (5) @(negedge clki);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: cycle %0d reached, required completion before 150000", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
